// File: rtl/rename_map_stage.sv
// 4-way rename stage: AR->PR map lookup/update with intra-bundle bypass,
// free-list pop, walkback restore and a one-deep registered output.
module rename_map_stage #(
    parameter int PR_W     = 7,
    parameter int AR_COUNT = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0][4:0]      A_AR_by_way,
    input  logic [3:0][4:0]      B_AR_by_way,
    input  logic [3:0]           regwrite_by_way,
    input  logic [3:0][4:0]      dest_AR_by_way,
    input  logic [3:0]           A_PR_dep_by_way,
    input  logic [3:0]           B_PR_dep_by_way,
    input  logic [3:0]           dest_PR_dep_by_way,
    input  logic [3:0][1:0]      A_PR_sel_by_way,
    input  logic [3:0][1:0]      B_PR_sel_by_way,
    input  logic [3:0][1:0]      dest_PR_sel_by_way,
    input  logic [3:0]           free_PR_valid_by_way,
    input  logic [3:0][PR_W-1:0] free_PR_by_way,
    output logic [3:0]           free_PR_pop_by_way,
    input  logic [3:0]           restore_valid_by_way,
    input  logic [3:0][4:0]      restore_AR_by_way,
    input  logic [3:0][PR_W-1:0] restore_PR_by_way,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0][PR_W-1:0] out_A_PR_by_way,
    output logic [3:0][PR_W-1:0] out_B_PR_by_way,
    output logic [3:0][PR_W-1:0] out_dest_PR_by_way,
    output logic [3:0][PR_W-1:0] out_old_dest_PR_by_way,
    output logic [3:0]           out_regwrite_by_way
);

    logic [PR_W-1:0]      map [AR_COUNT];
    logic                 restoring;
    logic                 free_ok;
    logic                 accept;
    logic [3:0][PR_W-1:0] a_pr;
    logic [3:0][PR_W-1:0] b_pr;
    logic [3:0][PR_W-1:0] d_pr;
    logic [3:0][PR_W-1:0] o_pr;

    assign restoring = |restore_valid_by_way;
    assign free_ok   = &(free_PR_valid_by_way | ~regwrite_by_way);
    // nRST gate keeps the free list untouched while reset is held
    assign in_ready  = nRST & ~restoring & free_ok & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign free_PR_pop_by_way = regwrite_by_way & {4{accept}};

    always_comb begin
        a_pr = '0;
        b_pr = '0;
        d_pr = '0;
        o_pr = '0;
        for (int i = 0; i < 4; i++) begin
            a_pr[i] = map[A_AR_by_way[i]];
            b_pr[i] = map[B_AR_by_way[i]];
            o_pr[i] = map[dest_AR_by_way[i]];
            if (i != 0 && A_PR_dep_by_way[i])
                a_pr[i] = free_PR_by_way[A_PR_sel_by_way[i]];
            if (i != 0 && B_PR_dep_by_way[i])
                b_pr[i] = free_PR_by_way[B_PR_sel_by_way[i]];
            if (i != 0 && dest_PR_dep_by_way[i])
                o_pr[i] = free_PR_by_way[dest_PR_sel_by_way[i]];
            if (regwrite_by_way[i])
                d_pr[i] = free_PR_by_way[i];
        end
    end

    // ascending loop: the later nonblocking write (higher way) wins
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < AR_COUNT; r++)
                map[r] <= PR_W'(r);
        end else if (restoring) begin
            for (int w = 0; w < 4; w++)
                if (restore_valid_by_way[w])
                    map[restore_AR_by_way[w]] <= restore_PR_by_way[w];
        end else if (accept) begin
            for (int w = 0; w < 4; w++)
                if (regwrite_by_way[w])
                    map[dest_AR_by_way[w]] <= free_PR_by_way[w];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid              <= 1'b0;
            out_A_PR_by_way        <= '0;
            out_B_PR_by_way        <= '0;
            out_dest_PR_by_way     <= '0;
            out_old_dest_PR_by_way <= '0;
            out_regwrite_by_way    <= '0;
        end else if (restoring) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid              <= 1'b1;
            out_A_PR_by_way        <= a_pr;
            out_B_PR_by_way        <= b_pr;
            out_dest_PR_by_way     <= d_pr;
            out_old_dest_PR_by_way <= o_pr;
            out_regwrite_by_way    <= regwrite_by_way;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rename_map_stage.sv
// Bench for rename_map_stage: directed cases plus random bundles against
// a sequential-rename reference model.
module tb_rename_map_stage;

    localparam int PR_W = 7;

    logic                 CLK = 1'b0;
    logic                 nRST;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0][4:0]      A_AR_by_way, B_AR_by_way, dest_AR_by_way;
    logic [3:0]           regwrite_by_way;
    logic [3:0]           A_PR_dep_by_way, B_PR_dep_by_way, dest_PR_dep_by_way;
    logic [3:0][1:0]      A_PR_sel_by_way, B_PR_sel_by_way, dest_PR_sel_by_way;
    logic [3:0]           free_PR_valid_by_way;
    logic [3:0][PR_W-1:0] free_PR_by_way;
    logic [3:0]           free_PR_pop_by_way;
    logic [3:0]           restore_valid_by_way;
    logic [3:0][4:0]      restore_AR_by_way;
    logic [3:0][PR_W-1:0] restore_PR_by_way;
    logic                 out_valid, out_ready;
    logic [3:0][PR_W-1:0] out_A_PR_by_way, out_B_PR_by_way;
    logic [3:0][PR_W-1:0] out_dest_PR_by_way, out_old_dest_PR_by_way;
    logic [3:0]           out_regwrite_by_way;

    rename_map_stage #(.PR_W(PR_W), .AR_COUNT(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready),
        .A_AR_by_way(A_AR_by_way), .B_AR_by_way(B_AR_by_way),
        .regwrite_by_way(regwrite_by_way), .dest_AR_by_way(dest_AR_by_way),
        .A_PR_dep_by_way(A_PR_dep_by_way), .B_PR_dep_by_way(B_PR_dep_by_way),
        .dest_PR_dep_by_way(dest_PR_dep_by_way),
        .A_PR_sel_by_way(A_PR_sel_by_way), .B_PR_sel_by_way(B_PR_sel_by_way),
        .dest_PR_sel_by_way(dest_PR_sel_by_way),
        .free_PR_valid_by_way(free_PR_valid_by_way),
        .free_PR_by_way(free_PR_by_way),
        .free_PR_pop_by_way(free_PR_pop_by_way),
        .restore_valid_by_way(restore_valid_by_way),
        .restore_AR_by_way(restore_AR_by_way),
        .restore_PR_by_way(restore_PR_by_way),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_A_PR_by_way(out_A_PR_by_way), .out_B_PR_by_way(out_B_PR_by_way),
        .out_dest_PR_by_way(out_dest_PR_by_way),
        .out_old_dest_PR_by_way(out_old_dest_PR_by_way),
        .out_regwrite_by_way(out_regwrite_by_way)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // reference state
    int   mmap [32];
    bit   m_valid;
    int   m_A [4], m_B [4], m_D [4], m_O [4];
    bit [3:0] m_rw;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) mmap[r] = r;
        m_valid = 0;
    endtask

    task automatic set_idle();
        in_valid             = 0;
        A_AR_by_way          = '0;
        B_AR_by_way          = '0;
        dest_AR_by_way       = '0;
        regwrite_by_way      = '0;
        free_PR_valid_by_way = 4'hF;
        free_PR_by_way       = {7'd43, 7'd42, 7'd41, 7'd40};
        restore_valid_by_way = '0;
        restore_AR_by_way    = '0;
        restore_PR_by_way    = '0;
        out_ready            = 1;
        A_PR_dep_by_way      = '0;
        B_PR_dep_by_way      = '0;
        dest_PR_dep_by_way   = '0;
        A_PR_sel_by_way      = '0;
        B_PR_sel_by_way      = '0;
        dest_PR_sel_by_way   = '0;
    endtask

    // plays the upstream dep checker: latest earlier writer of the same AR
    task automatic fix_deps();
        A_PR_dep_by_way    = '0;
        B_PR_dep_by_way    = '0;
        dest_PR_dep_by_way = '0;
        A_PR_sel_by_way    = '0;
        B_PR_sel_by_way    = '0;
        dest_PR_sel_by_way = '0;
        for (int i = 1; i < 4; i++)
            for (int j = 0; j < i; j++)
                if (regwrite_by_way[j]) begin
                    if (dest_AR_by_way[j] == A_AR_by_way[i]) begin
                        A_PR_dep_by_way[i] = 1; A_PR_sel_by_way[i] = 2'(j);
                    end
                    if (dest_AR_by_way[j] == B_AR_by_way[i]) begin
                        B_PR_dep_by_way[i] = 1; B_PR_sel_by_way[i] = 2'(j);
                    end
                    if (dest_AR_by_way[j] == dest_AR_by_way[i]) begin
                        dest_PR_dep_by_way[i] = 1; dest_PR_sel_by_way[i] = 2'(j);
                    end
                end
    endtask

    // one clock: check handshake before the edge, outputs after it
    task automatic cycle();
        bit restoring, fok, rdy, acc;
        int tmp [32];
        int eA [4], eB [4], eD [4], eO [4];
        restoring = |restore_valid_by_way;
        fok = 1;
        for (int i = 0; i < 4; i++)
            if (regwrite_by_way[i] && !free_PR_valid_by_way[i]) fok = 0;
        rdy = !restoring && fok && (!m_valid || out_ready);
        acc = in_valid && rdy;
        tmp = mmap;
        for (int i = 0; i < 4; i++) begin
            eA[i] = tmp[A_AR_by_way[i]];
            eB[i] = tmp[B_AR_by_way[i]];
            eO[i] = tmp[dest_AR_by_way[i]];
            eD[i] = regwrite_by_way[i] ? int'(free_PR_by_way[i]) : 0;
            if (regwrite_by_way[i]) tmp[dest_AR_by_way[i]] = free_PR_by_way[i];
        end
        @(negedge CLK);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("pop", 32'(free_PR_pop_by_way), acc ? 32'(regwrite_by_way) : 0);
        if (restoring) begin
            for (int w = 0; w < 4; w++)
                if (restore_valid_by_way[w])
                    mmap[restore_AR_by_way[w]] = restore_PR_by_way[w];
            m_valid = 0;
        end else if (acc) begin
            mmap = tmp;
            m_A = eA; m_B = eB; m_D = eD; m_O = eO;
            m_rw = regwrite_by_way;
            m_valid = 1;
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(posedge CLK);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_rw", 32'(out_regwrite_by_way), 32'(m_rw));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("A%0d", i), 32'(out_A_PR_by_way[i]), m_A[i]);
                chk($sformatf("B%0d", i), 32'(out_B_PR_by_way[i]), m_B[i]);
                chk($sformatf("D%0d", i), 32'(out_dest_PR_by_way[i]), m_D[i]);
                chk($sformatf("O%0d", i), 32'(out_old_dest_PR_by_way[i]), m_O[i]);
            end
        end
    endtask

    task automatic rand_bundle();
        int base;
        set_idle();
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        base = $urandom_range(32, 120);
        for (int i = 0; i < 4; i++) begin
            A_AR_by_way[i]     = 5'($urandom_range(0, 7));
            B_AR_by_way[i]     = 5'($urandom_range(0, 7));
            dest_AR_by_way[i]  = 5'($urandom_range(1, 7));
            regwrite_by_way[i] = 1'($urandom_range(0, 1));
            free_PR_by_way[i]  = 7'(base + i);
        end
        if ($urandom_range(0, 7) == 0)
            free_PR_valid_by_way = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) begin
            restore_valid_by_way = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                restore_AR_by_way[i] = 5'($urandom_range(1, 7));
                restore_PR_by_way[i] = 7'($urandom_range(0, 127));
            end
        end
        fix_deps();
    endtask

    initial begin
        nRST = 0;
        set_idle();
        model_reset();
        in_valid = 1;
        regwrite_by_way = 4'hF;
        #12;
        chk("rst_pop", 32'(free_PR_pop_by_way), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_A", 32'(out_A_PR_by_way), 0);
        chk("rst_old", 32'(out_old_dest_PR_by_way), 0);
        @(posedge CLK); #1;
        nRST = 1;
        set_idle();

        // single bundle
        A_AR_by_way[0] = 5; B_AR_by_way[0] = 6; dest_AR_by_way[0] = 7;
        regwrite_by_way = 4'b0001; in_valid = 1;
        cycle();
        chk("t1_A", 32'(out_A_PR_by_way[0]), 5);
        chk("t1_B", 32'(out_B_PR_by_way[0]), 6);
        chk("t1_D", 32'(out_dest_PR_by_way[0]), 40);
        chk("t1_O", 32'(out_old_dest_PR_by_way[0]), 7);
        set_idle();
        A_AR_by_way[1] = 7; in_valid = 1;
        cycle();
        chk("t1_map7", 32'(out_A_PR_by_way[1]), 40);

        // intra-bundle RAW/WAW
        set_idle();
        free_PR_by_way = {7'd53, 7'd52, 7'd51, 7'd50};
        regwrite_by_way = 4'b0101;
        dest_AR_by_way[0] = 3; dest_AR_by_way[2] = 3;
        A_AR_by_way[3] = 3; in_valid = 1;
        fix_deps();
        cycle();
        chk("t2_A3", 32'(out_A_PR_by_way[3]), 52);
        chk("t2_O2", 32'(out_old_dest_PR_by_way[2]), 50);
        set_idle();
        B_AR_by_way[0] = 3; in_valid = 1;
        cycle();
        chk("t2_map3", 32'(out_B_PR_by_way[0]), 52);

        // free-list starvation
        set_idle();
        regwrite_by_way = 4'hF;
        for (int i = 0; i < 4; i++) dest_AR_by_way[i] = 5'(10 + i);
        free_PR_valid_by_way = 4'b1011; in_valid = 1;
        cycle();
        cycle();
        chk("t3_stall", 32'(out_valid), 0);
        free_PR_valid_by_way = 4'hF;
        cycle();
        chk("t3_go", 32'(out_valid), 1);

        // backpressure
        set_idle();
        out_ready = 0; in_valid = 1;
        A_AR_by_way[0] = 12;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t4_hold", 32'(out_A_PR_by_way[0]), 5'd10 + 5'd0 == 0 ? 0 : 32'(m_A[0]));
        end
        out_ready = 1;
        cycle();
        chk("t4_next", 32'(out_A_PR_by_way[0]), 42);

        // restore while a bundle is offered
        set_idle();
        in_valid = 1; regwrite_by_way = 4'b0001; dest_AR_by_way[0] = 20;
        restore_valid_by_way = 4'b1010;
        restore_AR_by_way[1] = 7; restore_PR_by_way[1] = 7;
        restore_AR_by_way[3] = 7; restore_PR_by_way[3] = 9;
        cycle();
        chk("t5_flush", 32'(out_valid), 0);
        set_idle();
        A_AR_by_way[2] = 7; in_valid = 1;
        cycle();
        chk("t5_map7", 32'(out_A_PR_by_way[2]), 9);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rand_bundle();
            cycle();
        end

        // async reset with a bundle held at the output
        set_idle();
        in_valid = 1; out_ready = 0; A_AR_by_way[0] = 7;
        regwrite_by_way = 4'b0001; dest_AR_by_way[0] = 7;
        cycle();
        #2;
        nRST = 0;
        #1;
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_dest", 32'(out_dest_PR_by_way), 0);
        chk("t6_pop", 32'(free_PR_pop_by_way), 0);
        model_reset();
        @(posedge CLK); #1;
        nRST = 1;
        set_idle();
        A_AR_by_way[0] = 7; B_AR_by_way[1] = 3; in_valid = 1;
        cycle();
        chk("t6_map7", 32'(out_A_PR_by_way[0]), 7);
        chk("t6_map3", 32'(out_B_PR_by_way[1]), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rename_map_stage.md
Name: rename_map_stage

Overview:
- 4-way register rename pipeline stage, directly downstream of the architectural register dependence checker.
- Consumes each bundle's AR operands, regwrite, and intra-bundle dep/sel results, plus one free PR per way.
- Reads and updates a 32-entry AR->PR map table and produces a registered renamed bundle: A_PR, B_PR, dest_PR, old_dest_PR.
- Also supports a ROB-walkback restore port for map-table repair.

Parameters:
- PR_W, 7, physical register tag width
- AR_COUNT, 32, architectural registers (AR index 5 bits)

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- in_valid  in  1  bundle valid from dep-check stage
- in_ready  out  1  stage can accept bundle
- A_AR_by_way  in  4x5  source A ARs
- B_AR_by_way  in  4x5  source B ARs
- regwrite_by_way  in  4  way writes a dest (already 0 for x0 / invalid ways)
- dest_AR_by_way  in  4x5  dest ARs
- A_PR_dep_by_way, B_PR_dep_by_way, dest_PR_dep_by_way  in  4 each  intra-bundle dep flags
- A_PR_sel_by_way, B_PR_sel_by_way, dest_PR_sel_by_way  in  4x2 each  producing-way select
- free_PR_valid_by_way  in  4  free-list entry available for way i
- free_PR_by_way  in  4xPR_W  free PR offered to way i
- free_PR_pop_by_way  out  4  free-list consume, combinational
- restore_valid_by_way  in  4  walkback map writes this cycle
- restore_AR_by_way  in  4x5  AR to restore
- restore_PR_by_way  in  4xPR_W  PR to restore
- out_valid  out  1  renamed bundle valid
- out_ready  in  1  downstream accepts
- out_A_PR_by_way, out_B_PR_by_way, out_dest_PR_by_way, out_old_dest_PR_by_way  out  4xPR_W each  renamed tags
- out_regwrite_by_way  out  4  registered regwrite

Behaviour:
- Reset (nRST low, async):
  - map[i] = i for all i.
  - out_valid = 0; all out_* = 0.
- restoring = |restore_valid_by_way.
- free_ok = &(free_PR_valid_by_way | ~regwrite_by_way).
- in_ready = ~restoring & free_ok & (~out_valid | out_ready).
- accept = in_valid & in_ready.
- free_PR_pop_by_way = regwrite_by_way & {4{accept}}. Combinational, same cycle as accept; no pop otherwise.
- Per way i, rename combinationally from the pre-update map (the map state at the start of the cycle):
  - A_PR = A_PR_dep ? free_PR_by_way[A_PR_sel] : map[A_AR]; B_PR likewise.
  - dest_PR = free_PR_by_way[i] if regwrite, else 0.
  - old_dest_PR = dest_PR_dep ? free_PR_by_way[dest_PR_sel] : map[dest_AR].
- On accept: output registers load the renamed bundle at the next edge. Latency is 1 cycle.
- Map update on accept: for each AR, the highest-index way with regwrite and a matching dest_AR writes its free_PR. The last writer wins.
- Output hold:
  - out_valid & ~out_ready: all out_* hold stable, no accept.
  - out_valid & out_ready & ~accept: out_valid clears next cycle.
- Restore (any restore_valid):
  - Writes map[restore_AR] = restore_PR.
  - On equal ARs, the highest-index way wins.
  - Takes priority; accept is blocked that cycle.
  - out_valid is cleared next cycle, flushing the in-flight bundle regardless of out_ready.
- Dependence inputs are trusted: sel < i whenever dep is set, and way 0 deps are ignored.
- Writes to AR 0 are never issued by upstream. The block performs no x0 special-casing beyond reset map[0] = 0.
- No combinational path from out_ready to out_*; in_ready depends combinationally on out_ready.
- Reset mid-bundle: everything returns to reset state. No pops are issued while nRST is low.

Test Plan:
- Reset then single bundle:
  - Stimulus: way0 A_AR=5, B_AR=6, regwrite, dest_AR=7, free_PR=40; ways 1-3 no regwrite.
  - Response: 1 cycle later out A=5, B=6, dest=40, old=7; pop=0001; map[7]=40.
- Intra-bundle RAW/WAW:
  - Stimulus: way0 dest 3 / PR 50; way2 dest 3 / PR 52; way3 A_AR=3 with dep sel=2, dest_PR_dep on way2 sel=0.
  - Response: way3 A_PR=52; way2 old_dest=50; map[3]=52.
- Free-list starvation:
  - Stimulus: regwrite=1111, free_PR_valid=1011.
  - Response: in_ready=0, pop=0000, out_valid stays 0. Raise valid bit 2 -> accept that cycle.
- Backpressure:
  - Stimulus: out_ready=0 with out_valid=1, new in_valid.
  - Response: in_ready=0, outputs stable for 3 cycles. out_ready=1 -> next bundle accepted, appears the following cycle.
- Restore:
  - Stimulus: map[7]=40; restore way1 AR7->7 and way3 AR7->9 while in_valid=1.
  - Response: no accept, map[7]=9, out_valid 0 next cycle; a subsequent read of AR7 returns 9.
- Async reset mid-operation:
  - Stimulus: nRST low between edges with out_valid=1.
  - Response: out_valid=0 immediately, map identity restored.
